// File: rtl/rom_download_router_if.sv
// Bus bundle between the ioctl download source and the ROM download router.
// The router takes the slave view; the download source / bench takes the master view.
interface rom_download_router_if #(
  parameter int NUM_REGIONS = 4,
  parameter int REGION_LOG2 = 16,
  parameter int WORD_BYTES  = 2
);
  localparam int AW = REGION_LOG2 - $clog2(WORD_BYTES);

  logic                     ioctl_download;
  logic                     ioctl_wr;
  logic [24:0]              ioctl_addr;
  logic [7:0]               ioctl_dout;
  logic                     out_wr;
  logic [NUM_REGIONS-1:0]   out_cs;
  logic [AW-1:0]            out_addr;
  logic [8*WORD_BYTES-1:0]  out_data;
  logic [NUM_REGIONS-1:0]   region_done;
  logic [3:0]               sum_sel;
  logic [7:0]               sum_out;
  logic                     err_range;
  logic                     err_seq;
  logic                     busy;

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, sum_sel,
    output out_wr, out_cs, out_addr, out_data, region_done, sum_out,
           err_range, err_seq, busy
  );

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, sum_sel,
    input  out_wr, out_cs, out_addr, out_data, region_done, sum_out,
           err_range, err_seq, busy
  );
endinterface

// File: rtl/rom_download_router.sv
// ROM download router: splits the ioctl byte stream into equal-size regions,
// packs bytes into little-endian words and emits one-hot-selected word writes.
// Also tracks per-region byte counts / checksums and flags range and sequence errors.
module rom_download_router #(
  parameter int NUM_REGIONS = 4,
  parameter int REGION_LOG2 = 16,
  parameter int WORD_BYTES  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  rom_download_router_if.slave bus
);
  localparam int LB = $clog2(WORD_BYTES);
  localparam int LW = (LB == 0) ? 1 : LB;
  localparam int AW = REGION_LOG2 - LB;
  localparam int RW = (NUM_REGIONS <= 1) ? 1 : $clog2(NUM_REGIONS);
  localparam int CW = REGION_LOG2 + 1;
  localparam int DW = 8 * WORD_BYTES;
  localparam logic [CW-1:0] FULL     = {1'b1, {REGION_LOG2{1'b0}}};
  localparam logic [LW-1:0] TOP_LANE = LW'(WORD_BYTES - 1);

  logic                   dl_q, dl_d;
  logic [NUM_REGIONS-1:0] done_q, done_d;
  logic [CW-1:0]          cnt_q [NUM_REGIONS];
  logic [CW-1:0]          cnt_d [NUM_REGIONS];
  logic [7:0]             sum_q [NUM_REGIONS];
  logic [7:0]             sum_d [NUM_REGIONS];
  logic                   err_seq_q, err_seq_d;
  logic                   err_range_q, err_range_d;
  logic [24:0]            exp_q, exp_d;
  logic [DW-1:0]          lane_buf_q, lane_buf_d;
  logic                   part_q, part_d;
  logic [RW-1:0]          last_region_q, last_region_d;
  logic [AW-1:0]          last_waddr_q, last_waddr_d;
  logic                   out_wr_q, out_wr_d;
  logic [NUM_REGIONS-1:0] out_cs_q, out_cs_d;
  logic [AW-1:0]          out_addr_q, out_addr_d;
  logic [DW-1:0]          out_data_q, out_data_d;

  logic                   rise, fall, accept, in_range;
  logic [24:0]            idx;
  logic [RW-1:0]          region;
  logic [LW-1:0]          lane;

  // Next-state: edge-triggered clear, then apply the accepted byte or a flush.
  always_comb begin
    rise     = bus.ioctl_download & ~dl_q;
    fall     = ~bus.ioctl_download & dl_q;
    accept   = bus.ioctl_wr & bus.ioctl_download;
    idx      = bus.ioctl_addr >> REGION_LOG2;
    in_range = (idx < 25'(NUM_REGIONS));
    region   = idx[RW-1:0];
    lane     = LW'(bus.ioctl_addr % 25'(WORD_BYTES));

    dl_d          = bus.ioctl_download;
    last_region_d = last_region_q;
    last_waddr_d  = last_waddr_q;
    out_wr_d      = 1'b0;
    out_cs_d      = out_cs_q;
    out_addr_d    = out_addr_q;
    out_data_d    = out_data_q;

    // A new download starts from a clean slate in the same cycle as the rise.
    for (int r = 0; r < NUM_REGIONS; r++) begin
      done_d[r] = ~rise & (cnt_q[r] == FULL);
      cnt_d[r]  = rise ? '0 : cnt_q[r];
      sum_d[r]  = rise ? '0 : sum_q[r];
    end
    err_seq_d   = rise ? 1'b0 : err_seq_q;
    err_range_d = rise ? 1'b0 : err_range_q;
    exp_d       = rise ? '0 : exp_q;
    lane_buf_d  = rise ? '0 : lane_buf_q;
    part_d      = rise ? 1'b0 : part_q;

    if (accept) begin
      // Out-of-sequence bytes are still processed; only the flag is raised.
      if (bus.ioctl_addr != exp_d) begin
        err_seq_d = 1'b1;
      end
      exp_d = bus.ioctl_addr + 25'd1;
      if (!in_range) begin
        err_range_d = 1'b1;
      end else begin
        sum_d[region] = sum_d[region] + bus.ioctl_dout;
        if (cnt_d[region] != FULL) begin
          cnt_d[region] = cnt_d[region] + CW'(1);
        end
        for (int i = 0; i < WORD_BYTES; i++) begin
          if (lane == LW'(i)) begin
            lane_buf_d[i*8 +: 8] = bus.ioctl_dout;
          end
        end
        last_region_d = region;
        last_waddr_d  = bus.ioctl_addr[REGION_LOG2-1:LB];
        if (lane == TOP_LANE) begin
          out_wr_d   = 1'b1;
          out_cs_d   = NUM_REGIONS'(1) << region;
          out_addr_d = bus.ioctl_addr[REGION_LOG2-1:LB];
          out_data_d = lane_buf_d;
          lane_buf_d = '0;
          part_d     = 1'b0;
        end else begin
          part_d = 1'b1;
        end
      end
    end else if (fall && part_q) begin
      // Download ended mid-word: push out what we have, unwritten lanes are zero.
      out_wr_d   = 1'b1;
      out_cs_d   = NUM_REGIONS'(1) << last_region_q;
      out_addr_d = last_waddr_q;
      out_data_d = lane_buf_q;
      lane_buf_d = '0;
      part_d     = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      dl_q          <= 1'b0;
      done_q        <= '0;
      for (int r = 0; r < NUM_REGIONS; r++) begin
        cnt_q[r] <= '0;
        sum_q[r] <= '0;
      end
      err_seq_q     <= 1'b0;
      err_range_q   <= 1'b0;
      exp_q         <= '0;
      lane_buf_q    <= '0;
      part_q        <= 1'b0;
      last_region_q <= '0;
      last_waddr_q  <= '0;
      out_wr_q      <= 1'b0;
      out_cs_q      <= '0;
      out_addr_q    <= '0;
      out_data_q    <= '0;
    end else begin
      dl_q          <= dl_d;
      done_q        <= done_d;
      cnt_q         <= cnt_d;
      sum_q         <= sum_d;
      err_seq_q     <= err_seq_d;
      err_range_q   <= err_range_d;
      exp_q         <= exp_d;
      lane_buf_q    <= lane_buf_d;
      part_q        <= part_d;
      last_region_q <= last_region_d;
      last_waddr_q  <= last_waddr_d;
      out_wr_q      <= out_wr_d;
      out_cs_q      <= out_cs_d;
      out_addr_q    <= out_addr_d;
      out_data_q    <= out_data_d;
    end
  end

  // Checksum readback: pad to all 16 selectable indices, missing regions read 0.
  logic [7:0] sum_view [16];
  for (genvar gi = 0; gi < 16; gi++) begin : g_sum_view
    if (gi < NUM_REGIONS) begin : g_live
      assign sum_view[gi] = sum_q[gi];
    end else begin : g_pad
      assign sum_view[gi] = 8'h00;
    end
  end

  assign bus.sum_out     = sum_view[bus.sum_sel];
  assign bus.out_wr      = out_wr_q;
  assign bus.out_cs      = out_cs_q;
  assign bus.out_addr    = out_addr_q;
  assign bus.out_data    = out_data_q;
  assign bus.region_done = done_q;
  assign bus.err_seq     = err_seq_q;
  assign bus.err_range   = err_range_q;
  assign bus.busy        = bus.ioctl_download | (dl_q & part_q);
endmodule

// File: tb/tb_rom_download_router.sv
// Bench for rom_download_router: two instances (default geometry and a
// 2 x 4 KB / 32-bit-word geometry) share one ioctl stream and are checked
// every cycle against a byte-level reference model.
`timescale 1ns/1ps
module tb_rom_download_router;
  logic        clk;
  logic        reset;
  logic        ioctl_download, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [3:0]  sum_sel;

  int checks = 0;
  int errors = 0;
  bit verbose = 1;

  rom_download_router_if #(.NUM_REGIONS(4), .REGION_LOG2(16), .WORD_BYTES(2)) ifa();
  rom_download_router_if #(.NUM_REGIONS(2), .REGION_LOG2(12), .WORD_BYTES(4)) ifb();

  assign ifa.ioctl_download = ioctl_download;
  assign ifa.ioctl_wr       = ioctl_wr;
  assign ifa.ioctl_addr     = ioctl_addr;
  assign ifa.ioctl_dout     = ioctl_dout;
  assign ifa.sum_sel        = sum_sel;
  assign ifb.ioctl_download = ioctl_download;
  assign ifb.ioctl_wr       = ioctl_wr;
  assign ifb.ioctl_addr     = ioctl_addr;
  assign ifb.ioctl_dout     = ioctl_dout;
  assign ifb.sum_sel        = sum_sel;

  rom_download_router #(.NUM_REGIONS(4), .REGION_LOG2(16), .WORD_BYTES(2)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa));
  rom_download_router #(.NUM_REGIONS(2), .REGION_LOG2(12), .WORD_BYTES(4)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, index 0 = instance A, 1 = instance B.
  int          m_exp [2];
  logic [7:0]  m_lane [2][4];
  bit          m_part [2];
  bit          m_wr [2];
  logic [31:0] m_cs [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_data [2];
  logic [7:0]  m_sum [2][16];
  int          m_cnt [2][16];
  bit          m_done [2][16];
  bit          m_eseq [2];
  bit          m_erng [2];
  int          m_last_reg [2];
  int          m_last_wa [2];
  int          m_nemit [2];
  int          o_nemit [2];
  bit          prev_dl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_new_download(input int k);
    m_exp[k] = 0; m_part[k] = 0; m_eseq[k] = 0; m_erng[k] = 0;
    for (int i = 0; i < 4; i++) m_lane[k][i] = 8'h00;
    for (int r = 0; r < 16; r++) begin m_sum[k][r] = 8'h00; m_cnt[k][r] = 0; end
  endtask

  task automatic model_reset();
    prev_dl = 0;
    for (int k = 0; k < 2; k++) begin
      model_new_download(k);
      m_wr[k] = 0; m_cs[k] = 0; m_addr[k] = 0; m_data[k] = 0;
      m_last_reg[k] = 0; m_last_wa[k] = 0;
      for (int r = 0; r < 16; r++) m_done[k][r] = 0;
    end
  endtask

  // Emit whatever bytes have been collected as one little-endian word.
  task automatic model_emit(input int k, input int wb);
    m_wr[k] = 1;
    m_cs[k] = 32'd1 << m_last_reg[k];
    m_addr[k] = m_last_wa[k];
    m_data[k] = 0;
    for (int i = 0; i < wb; i++) begin
      m_data[k][i*8 +: 8] = m_lane[k][i];
      m_lane[k][i] = 8'h00;
    end
    m_part[k] = 0;
    m_nemit[k]++;
  endtask

  task automatic model(input int k, input int wb, input int rl, input int nr,
                       input bit dl, input bit wr, input logic [24:0] addr, input logic [7:0] d);
    int full, a, rg, ln;
    bit rise, fall;
    full = 1 << rl;
    a    = int'(addr);
    rise = dl && !prev_dl;
    fall = !dl && prev_dl;
    m_wr[k] = 0;
    for (int r = 0; r < nr; r++) m_done[k][r] = !rise && (m_cnt[k][r] == full);
    if (rise) model_new_download(k);
    if (dl && wr) begin
      if (a != m_exp[k]) m_eseq[k] = 1;
      m_exp[k] = (a + 1) % (1 << 25);
      rg = a >> rl;
      if (rg >= nr) begin
        m_erng[k] = 1;
      end else begin
        m_sum[k][rg] += d;
        if (m_cnt[k][rg] < full) m_cnt[k][rg]++;
        ln = a % wb;
        m_lane[k][ln] = d;
        m_part[k] = 1;
        m_last_reg[k] = rg;
        m_last_wa[k] = (a % full) / wb;
        if (ln == wb - 1) model_emit(k, wb);
      end
    end else if (fall && m_part[k]) begin
      model_emit(k, wb);
    end
  endtask

  function automatic logic [31:0] done_vec(input int k, input int nr);
    logic [31:0] v;
    v = 0;
    for (int r = 0; r < nr; r++) v[r] = m_done[k][r];
    return v;
  endfunction

  task automatic check_outputs();
    if (ifa.out_wr) o_nemit[0]++;
    if (ifb.out_wr) o_nemit[1]++;
    chk("a_out_wr",    32'(ifa.out_wr),      32'(m_wr[0]));
    chk("a_out_cs",    32'(ifa.out_cs),      m_cs[0]);
    chk("a_out_addr",  32'(ifa.out_addr),    m_addr[0]);
    chk("a_out_data",  32'(ifa.out_data),    m_data[0]);
    chk("a_done",      32'(ifa.region_done), done_vec(0, 4));
    chk("a_err_seq",   32'(ifa.err_seq),     32'(m_eseq[0]));
    chk("a_err_range", 32'(ifa.err_range),   32'(m_erng[0]));
    chk("b_out_wr",    32'(ifb.out_wr),      32'(m_wr[1]));
    chk("b_out_cs",    32'(ifb.out_cs),      m_cs[1]);
    chk("b_out_addr",  32'(ifb.out_addr),    m_addr[1]);
    chk("b_out_data",  32'(ifb.out_data),    m_data[1]);
    chk("b_done",      32'(ifb.region_done), done_vec(1, 2));
    chk("b_err_seq",   32'(ifb.err_seq),     32'(m_eseq[1]));
    chk("b_err_range", 32'(ifb.err_range),   32'(m_erng[1]));
  endtask

  // One clock of stimulus; busy is checked before the edge, everything else after.
  task automatic step(input bit dl, input bit wr, input logic [24:0] addr, input logic [7:0] d);
    ioctl_download = dl; ioctl_wr = wr; ioctl_addr = addr; ioctl_dout = d;
    #1;
    chk("a_busy", 32'(ifa.busy), 32'(dl || (prev_dl && m_part[0])));
    chk("b_busy", 32'(ifb.busy), 32'(dl || (prev_dl && m_part[1])));
    model(0, 2, 16, 4, dl, wr, addr, d);
    model(1, 4, 12, 2, dl, wr, addr, d);
    prev_dl = dl;
    @(posedge clk); #1;
    check_outputs();
    if (verbose)
      $display("step dl=%0d wr=%0d addr=%07h d=%02h | A wr=%0d cs=%0h wa=%0h data=%04h | B wr=%0d cs=%0h wa=%0h data=%08h",
               dl, wr, addr, d, ifa.out_wr, ifa.out_cs, ifa.out_addr, ifa.out_data,
               ifb.out_wr, ifb.out_cs, ifb.out_addr, ifb.out_data);
  endtask

  task automatic byte_wr(input logic [24:0] addr, input logic [7:0] d);
    step(1, 1, addr, d);
    step(1, 0, addr, 8'h00);
  endtask

  task automatic do_reset();
    reset = 1; ioctl_download = 0; ioctl_wr = 0; ioctl_addr = 0; ioctl_dout = 0;
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    check_outputs();
    chk("a_busy_rst", 32'(ifa.busy), 32'd0);
    chk("b_busy_rst", 32'(ifb.busy), 32'd0);
    $display("reset applied");
  endtask

  // Checksum readback over a handful of selects (fits between two clock edges).
  task automatic check_sums();
    int sels [5] = '{0, 1, 2, 3, 9};
    for (int i = 0; i < 5; i++) begin
      sum_sel = 4'(sels[i]);
      #1;
      chk("a_sum", 32'(ifa.sum_out), 32'((sels[i] < 4) ? m_sum[0][sels[i]] : 8'h00));
      chk("b_sum", 32'(ifb.sum_out), 32'((sels[i] < 2) ? m_sum[1][sels[i]] : 8'h00));
    end
    sum_sel = 0;
  endtask

  initial begin
    logic [24:0] nxt, ad;
    int sel, base_a, base_b;
    bit dl_r;
    reset = 1; ioctl_download = 0; ioctl_wr = 0; ioctl_addr = 0; ioctl_dout = 0; sum_sel = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    check_sums();

    // Three bytes then drop download: one full word, then a flushed partial word.
    step(1, 0, 0, 0);
    byte_wr(0, 8'hAA);
    step(1, 1, 1, 8'hBB);
    chk("tp_word_data", 32'(ifa.out_data), 32'h0000BBAA);
    chk("tp_word_addr", 32'(ifa.out_addr), 32'h0);
    step(1, 0, 0, 0);
    byte_wr(2, 8'hCC);
    step(0, 0, 0, 0);
    chk("tp_flush_wr",   32'(ifa.out_wr),   32'h1);
    chk("tp_flush_data", 32'(ifa.out_data), 32'h000000CC);
    chk("tp_flush_addr", 32'(ifa.out_addr), 32'h1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Out-of-range byte: dropped, sticky range error.
    step(1, 0, 0, 0);
    byte_wr(25'h40000, 8'h5A);
    chk("tp_range_err", 32'(ifa.err_range), 32'h1);
    check_sums();
    step(0, 0, 0, 0);

    // Address gap: sequence error but bytes still land.
    step(1, 0, 0, 0);
    byte_wr(0, 8'h01);
    byte_wr(1, 8'h02);
    byte_wr(5, 8'h03);
    chk("tp_seq_err", 32'(ifa.err_seq), 32'h1);
    step(0, 0, 0, 0);
    chk("tp_seq_flush_addr", 32'(ifa.out_addr), 32'h2);
    step(0, 0, 0, 0);

    // Reset mid-word discards the partial word; a new download starts clean.
    step(1, 0, 0, 0);
    byte_wr(0, 8'h77);
    do_reset();
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    byte_wr(0, 8'h10);
    byte_wr(1, 8'h20);
    chk("tp_after_rst_data", 32'(ifa.out_data), 32'h00002010);
    step(0, 0, 0, 0);

    // Region boundaries on the default geometry, byte = addr[7:0].
    step(1, 0, 0, 0);
    byte_wr(0, 8'h00);
    step(1, 1, 1, 8'h01);
    chk("tp_first_cs",   32'(ifa.out_cs),   32'h1);
    chk("tp_first_addr", 32'(ifa.out_addr), 32'h0);
    chk("tp_first_data", 32'(ifa.out_data), 32'h0100);
    step(1, 0, 0, 0);
    byte_wr(25'h10000, 8'h00);
    step(1, 1, 25'h10001, 8'h01);
    chk("tp_r1_cs",   32'(ifa.out_cs),   32'h2);
    chk("tp_r1_addr", 32'(ifa.out_addr), 32'h0);
    step(0, 0, 0, 0);

    // Small geometry: one 32-bit word into region 1, out-of-order lane writes.
    step(1, 0, 0, 0);
    byte_wr(25'h1000, 8'h11);
    byte_wr(25'h1001, 8'h22);
    byte_wr(25'h1002, 8'h33);
    step(1, 1, 25'h1003, 8'h44);
    chk("tp_b_cs",   32'(ifb.out_cs),   32'h2);
    chk("tp_b_addr", 32'(ifb.out_addr), 32'h0);
    chk("tp_b_data", 32'(ifb.out_data), 32'h44332211);
    sum_sel = 4'd1; #1;
    chk("tp_b_sum", 32'(ifb.sum_out), 32'hAA);
    step(1, 0, 0, 0);
    byte_wr(25'h6, 8'h66);
    byte_wr(25'h5, 8'h55);
    byte_wr(25'h7, 8'h77);
    byte_wr(25'h4, 8'h44);
    step(1, 1, 25'h8, 8'h88);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check_sums();

    // Randomized bursts: mostly sequential, some jumps, out-of-range and wrap.
    nxt = 0; dl_r = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) dl_r = !dl_r;
      sel = $urandom_range(0, 9);
      if (sel <= 5)      ad = nxt;
      else if (sel <= 7) ad = 25'($urandom_range(0, 20));
      else if (sel == 8) ad = 25'h3FFFE + 25'($urandom_range(0, 3));
      else               ad = 25'h1FFFFFF;
      if ($urandom_range(0, 1) == 1) begin
        step(dl_r, 1, ad, 8'($urandom));
        if (dl_r) nxt = ad + 25'd1;
      end else begin
        step(dl_r, 0, ad, 8'($urandom));
      end
      if (i % 50 == 0) check_sums();
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Full download of the small geometry with random data and random gaps.
    verbose = 0;
    base_a = o_nemit[0]; base_b = o_nemit[1];
    step(1, 0, 0, 0);
    for (int a = 0; a < 8192; a++) begin
      step(1, 1, 25'(a), 8'($urandom));
      if ($urandom_range(0, 1) == 1) step(1, 0, 0, 0);
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    verbose = 1;
    $display("bulk download done: A emits=%0d B emits=%0d", o_nemit[0] - base_a, o_nemit[1] - base_b);
    chk("bulk_b_done",    32'(ifb.region_done), 32'h3);
    chk("bulk_b_err_seq", 32'(ifb.err_seq),     32'h0);
    chk("bulk_b_err_rng", 32'(ifb.err_range),   32'h0);
    chk("bulk_b_emits",   32'(o_nemit[1] - base_b), 32'd2048);
    chk("bulk_a_emits",   32'(o_nemit[0] - base_a), 32'd4096);
    chk("bulk_model_emits_b", 32'(o_nemit[1]), 32'(m_nemit[1]));
    check_sums();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rom_download_router.md
Name: rom_download_router

Overview:
- Parametrised successor to the fixed four-region download selector and byte-wide EPROM write path.
- Takes the MiSTer ioctl byte stream and decodes the address into NUM_REGIONS contiguous equal-size regions.
- Packs bytes into WORD_BYTES-wide little-endian words and issues one-hot-selected word writes to downstream dual-port ROM banks.
- Tracks per-region completion and 8-bit checksums, and flags out-of-range or non-sequential addresses so the top level can gate CPU reset until ROMs are valid.

Parameters:
NUM_REGIONS, 4, number of ROM regions (1..16)
REGION_LOG2, 16, log2 of region size in bytes
WORD_BYTES, 2, bytes per output word (1, 2 or 4)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ioctl_download  in  1  download active
ioctl_wr  in  1  byte strobe, one cycle per byte
ioctl_addr  in  25  byte address
ioctl_dout  in  8  byte data
out_wr  out  1  word write strobe, one-cycle pulse
out_cs  out  NUM_REGIONS  one-hot region select, valid with out_wr
out_addr  out  REGION_LOG2-log2(WORD_BYTES)  word address within region
out_data  out  8*WORD_BYTES  packed word; byte lane n = byte address offset n
region_done  out  NUM_REGIONS  region received all 2^REGION_LOG2 bytes
sum_sel  in  4  region index for checksum readback
sum_out  out  8  additive checksum of sum_sel region (combinational mux of registers)
err_range  out  1  sticky: byte at address >= NUM_REGIONS<<REGION_LOG2
err_seq  out  1  sticky: byte address != previous accepted address + 1
busy  out  1  download active or flush pending

Behaviour:
- Reset, synchronous active-high: all outputs 0, checksums 0, byte counters 0, lane buffer 0, expected address 0, flush flag 0. Reset mid-download drops any partial word; no out_wr is issued.
- Rising edge of ioctl_download (registered compare) clears: region_done, checksums, counters, err flags, lane buffer and expected address. Clearing takes effect in that same cycle.
- Byte acceptance: ioctl_wr=1 while ioctl_download=1.
- Region index: ioctl_addr >> REGION_LOG2. If the index is >= NUM_REGIONS, the byte is dropped and err_range is set the next cycle.
- Sequence check: any accepted byte with ioctl_addr != expected sets err_seq, but the byte is still processed. The first byte after the rising edge expects address 0. Expected address becomes ioctl_addr+1 after every accepted byte, in range or not.
- Lane write: the byte is written to lane ioctl_addr[log2(WORD_BYTES)-1:0] of the lane buffer.
- Checksum: the region's checksum adds the byte mod 256.
- Byte counter: the region's counter increments, saturating at 2^REGION_LOG2. region_done[r] rises the cycle after the counter reaches 2^REGION_LOG2.
- Word emit: when the byte lands in lane WORD_BYTES-1, the next cycle carries:
  - out_wr=1
  - out_cs=1<<region
  - out_addr = ioctl_addr[REGION_LOG2-1:log2(WORD_BYTES)]
  - out_data = lane buffer including the new byte
  The lane buffer then clears. Latency is exactly 1 cycle. out_cs, out_addr and out_data hold their values until the next emit; out_wr is high for one cycle only.
- WORD_BYTES=1: every accepted byte emits.
- Flush: on the falling edge of ioctl_download with a partial word (any lane written since the last emit), emit once the next cycle using the last region/word address. Unwritten lanes are 0.
- Simultaneous ioctl_wr and ioctl_download falling: the byte is accepted normally in that cycle (ioctl_download still high), then a flush occurs if a partial word remains. No double emit.
- Emit/flush rate: at most one emit per cycle. The ioctl protocol guarantees at least 1 idle cycle between ioctl_wr pulses, so no back-pressure is needed. Back-to-back ioctl_wr is still handled, since emit is registered each cycle.
- Byte lands in a lower lane after the upper lane was already written (out-of-order data): no emit; lanes are overwritten as written.
- busy = ioctl_download | flush pending.
- Address wrap: ioctl_addr is never masked before range check; 25-bit arithmetic for expected address wraps at 2^25.

Test Plan:
- Defaults; download addresses 0x00000..0x3FFFF with byte = addr[7:0]:
  - 0x20000 out_wr pulses total.
  - First emit: out_cs=4'b0001, out_addr=0, out_data=16'h0100.
  - Emit for byte 0x10001: out_cs=4'b0010, out_addr=0.
  - region_done=4'b1111; err_seq=0, err_range=0.
  - sum_out for each region = 0x00 (256 full cycles of 0..255 per 64 KB).
- Download 3 bytes 0xAA,0xBB,0xCC at 0,1,2, then drop ioctl_download:
  - Emit 16'hBBAA at out_addr 0.
  - One cycle after the fall, flush emit 16'h00CC at out_addr 1.
  - busy low the cycle after the flush.
- Byte at 0x40000 (defaults) -> no out_wr, err_range=1 next cycle, checksums unchanged.
- Bytes at 0, 1, then 5 -> err_seq=1 on the third byte; two words emitted (addr 0; addr 2 after the flush).
- Assert reset mid-word after byte at address 0 -> no out_wr; all outputs 0. A new download of addresses 0..1 emits only the new data.
- WORD_BYTES=4, NUM_REGIONS=2, REGION_LOG2=12:
  - Bytes 0x11,0x22,0x33,0x44 at 0x1000..0x1003 -> one emit, out_cs=2'b10, out_addr=0, out_data=32'h44332211, one cycle after the 0x1003 strobe.
  - sum_sel=1 -> sum_out=0xAA.
